dual_issue_ctrl: RTL and testbench

In-order, dual-issue instruction issue controller sitting directly upstream of the scoreboard. It buffers decoded instructions, looks up source readiness through the scoreboard read ports and picks zero, one or two instructions per cycle. It drives the scoreboard issue/write-allocate ports and registers the issued pair, with its forwarding IDs, into the execute-stage input registers.

---
 rtl/issue_pkg.sv | 21 ++
 rtl/issue_fifo.sv | 80 ++++++++
 rtl/dual_issue_ctrl.sv | 111 +++++++++++
 tb/tb_dual_issue_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types for the dual-issue controller: per-instruction control fields and issue geometry.
// The payload sits in a parallel array because its width is a module parameter.
package issue_pkg;

    localparam int ISSUE_WIDTH  = 2;
    localparam int SRC_PER_INST = 2;
    localparam int REG_W        = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t                    rd;
        reg_idx_t [SRC_PER_INST-1:0] rs;
        logic                        pipe0_only;
    } issue_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// DEPTH-entry circular instruction buffer, two writes and two reads per cycle,
// exposing the two oldest entries combinationally.
module issue_fifo
    import issue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [ISSUE_WIDTH-1:0]                push,
    input  issue_entry_t [ISSUE_WIDTH-1:0]        push_entry,
    input  logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0] push_payload,
    input  logic [ISSUE_WIDTH-1:0]                pop,
    output logic                                  ready,
    output logic [$clog2(DEPTH):0]                count,
    output reg_idx_t                              head_rd,
    output reg_idx_t [SRC_PER_INST-1:0]           head_rs,
    output logic [PAYLOAD_W-1:0]                  head_payload,
    output issue_entry_t                          next,
    output logic [PAYLOAD_W-1:0]                  next_payload
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    issue_entry_t         mem [DEPTH];
    logic [PAYLOAD_W-1:0] pay [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr1;
    logic [PTR_W-1:0]     rd_ptr1;
    logic [ISSUE_WIDTH-1:0] acc;
    logic [1:0]           enq_cnt;
    logic [1:0]           deq_cnt;

    // Acceptance uses only the registered count, so a full buffer never bypasses a same-cycle pop.
    assign ready   = count <= CNT_W'(DEPTH - 2);
    assign acc     = push & {ISSUE_WIDTH{ready && !flush}};
    assign enq_cnt = popcount2(acc);
    assign deq_cnt = popcount2(pop);
    assign wr_ptr1 = wr_ptr + PTR_W'(1);
    assign rd_ptr1 = rd_ptr + PTR_W'(1);

    assign head_rd      = mem[rd_ptr].rd;
    assign head_rs      = mem[rd_ptr].rs;
    assign head_payload = pay[rd_ptr];
    assign next         = mem[rd_ptr1];
    assign next_payload = pay[rd_ptr1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
                pay[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (acc[0]) begin
                mem[wr_ptr] <= push_entry[0];
                pay[wr_ptr] <= push_payload[0];
            end
            if (acc[1]) begin
                mem[wr_ptr1] <= push_entry[1];
                pay[wr_ptr1] <= push_payload[1];
            end
            wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
            rd_ptr <= rd_ptr + PTR_W'(deq_cnt);
            count  <= count + CNT_W'(enq_cnt) - CNT_W'(deq_cnt);
        end
    end

endmodule

// File: rtl/dual_issue_ctrl.sv
// In-order dual-issue controller: buffers decoded instructions, checks scoreboard readiness
// and intra-pair hazards, and registers the issued pair for the execute stage.
module dual_issue_ctrl
    import issue_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 4
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                flush_i,
    input  logic [ISSUE_WIDTH-1:0]                              in_valid_i,
    output logic                                                in_ready_o,
    input  logic [ISSUE_WIDTH-1:0][REG_W-1:0]                   in_rd_i,
    input  logic [ISSUE_WIDTH-1:0][SRC_PER_INST-1:0][REG_W-1:0] in_rs_i,
    input  logic [ISSUE_WIDTH-1:0]                              in_pipe0_only_i,
    input  logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]               in_payload_i,
    input  logic                                                sb_ready_i,
    output logic [3:0][REG_W-1:0]                               sb_r_addr_o,
    input  logic [3:0]                                          sb_r_valid_i,
    input  logic [3:0][3:0]                                     sb_r_id_i,
    output logic [ISSUE_WIDTH-1:0][REG_W-1:0]                   sb_w_addr_o,
    output logic [ISSUE_WIDTH-1:0]                              sb_is_o,
    input  logic [4:0]                                          sb_w_id_i,
    input  logic                                                out_ready_i,
    output logic [ISSUE_WIDTH-1:0]                              out_valid_o,
    output logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]               out_payload_o,
    output logic [3:0][3:0]                                     out_r_id_o,
    output logic [4:0]                                          out_w_id_o,
    output logic [ISSUE_WIDTH-1:0][REG_W-1:0]                   out_rd_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    issue_entry_t [ISSUE_WIDTH-1:0] push_entry;
    logic [CNT_W-1:0]               count;
    reg_idx_t                       head_rd;
    reg_idx_t [SRC_PER_INST-1:0]    head_rs;
    logic [PAYLOAD_W-1:0]           head_payload;
    issue_entry_t                   next;
    logic [PAYLOAD_W-1:0]           next_payload;
    logic                           out_free;
    logic                           raw;
    logic                           waw;
    logic                           can0;
    logic                           can1;

    always_comb begin
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            push_entry[s].rd         = in_rd_i[s];
            push_entry[s].rs         = in_rs_i[s];
            push_entry[s].pipe0_only = in_pipe0_only_i[s];
        end
    end

    issue_fifo #(
        .DEPTH     (DEPTH),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush_i),
        .push         (in_valid_i),
        .push_entry   (push_entry),
        .push_payload (in_payload_i),
        .pop          (sb_is_o),
        .ready        (in_ready_o),
        .count        (count),
        .head_rd      (head_rd),
        .head_rs      (head_rs),
        .head_payload (head_payload),
        .next         (next),
        .next_payload (next_payload)
    );

    assign sb_r_addr_o = {next.rs[1], next.rs[0], head_rs[1], head_rs[0]};
    assign sb_w_addr_o = {next.rd, head_rd};

    // Register 0 never creates a dependency, so a zero head.rd disables both pair hazards.
    assign raw = (head_rd != '0) && ((head_rd == next.rs[0]) || (head_rd == next.rs[1]));
    assign waw = (head_rd != '0) && (head_rd == next.rd);

    assign out_free = !(|out_valid_o) || out_ready_i;
    assign can0     = (count != '0) && sb_ready_i && out_free && !flush_i
                      && sb_r_valid_i[0] && sb_r_valid_i[1];
    assign can1     = can0 && (count >= CNT_W'(2)) && sb_r_valid_i[2] && sb_r_valid_i[3]
                      && !next.pipe0_only && !raw && !waw;
    assign sb_is_o  = {can1, can0};

    // Execute-stage input register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_o   <= '0;
            out_payload_o <= '0;
            out_r_id_o    <= '0;
            out_w_id_o    <= '0;
            out_rd_o      <= '0;
        end else if (flush_i) begin
            out_valid_o <= '0;
        end else if (can0) begin
            out_valid_o   <= {can1, 1'b1};
            out_payload_o <= {next_payload, head_payload};
            out_rd_o      <= {next.rd, head_rd};
            out_r_id_o    <= sb_r_id_i;
            out_w_id_o    <= sb_w_id_i;
        end else if (out_ready_i) begin
            out_valid_o <= '0;
        end
    end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Directed bench for dual_issue_ctrl: pair issue, hazards, scoreboard/downstream stalls,
// flush and reset, each with hand-computed expectations.
module tb_dual_issue_ctrl;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush_i;
    logic [1:0]            in_valid_i;
    logic                  in_ready_o;
    logic [1:0][4:0]       in_rd_i;
    logic [1:0][1:0][4:0]  in_rs_i;
    logic [1:0]            in_pipe0_only_i;
    logic [1:0][63:0]      in_payload_i;
    logic                  sb_ready_i;
    logic [3:0][4:0]       sb_r_addr_o;
    logic [3:0]            sb_r_valid_i;
    logic [3:0][3:0]       sb_r_id_i;
    logic [1:0][4:0]       sb_w_addr_o;
    logic [1:0]            sb_is_o;
    logic [4:0]            sb_w_id_i;
    logic                  out_ready_i;
    logic [1:0]            out_valid_o;
    logic [1:0][63:0]      out_payload_o;
    logic [3:0][3:0]       out_r_id_o;
    logic [4:0]            out_w_id_o;
    logic [1:0][4:0]       out_rd_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dual_issue_ctrl #(
        .PAYLOAD_W (64),
        .DEPTH     (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_rd_i         (in_rd_i),
        .in_rs_i         (in_rs_i),
        .in_pipe0_only_i (in_pipe0_only_i),
        .in_payload_i    (in_payload_i),
        .sb_ready_i      (sb_ready_i),
        .sb_r_addr_o     (sb_r_addr_o),
        .sb_r_valid_i    (sb_r_valid_i),
        .sb_r_id_i       (sb_r_id_i),
        .sb_w_addr_o     (sb_w_addr_o),
        .sb_is_o         (sb_is_o),
        .sb_w_id_i       (sb_w_id_i),
        .out_ready_i     (out_ready_i),
        .out_valid_o     (out_valid_o),
        .out_payload_o   (out_payload_o),
        .out_r_id_o      (out_r_id_o),
        .out_w_id_o      (out_w_id_o),
        .out_rd_o        (out_rd_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_slot(input int s, input logic [4:0] rd, input logic [4:0] rs0,
                            input logic [4:0] rs1, input logic p0, input logic [63:0] pay);
        in_rd_i[s]         = rd;
        in_rs_i[s][0]      = rs0;
        in_rs_i[s][1]      = rs1;
        in_pipe0_only_i[s] = p0;
        in_payload_i[s]    = pay;
    endtask

    initial begin
        rst_n           = 1'b0;
        flush_i         = 1'b0;
        in_valid_i      = 2'b00;
        in_rd_i         = '0;
        in_rs_i         = '0;
        in_pipe0_only_i = '0;
        in_payload_i    = '0;
        sb_ready_i      = 1'b1;
        sb_r_valid_i    = 4'hF;
        sb_r_id_i       = 16'h4321;
        sb_w_id_i       = 5'h0A;
        out_ready_i     = 1'b1;

        // Reset state
        step();
        step();
        rst_n = 1'b1;
        step();
        settle();
        chk("rst_out_valid", out_valid_o, 2'b00);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_sb_is", sb_is_o, 2'b00);
        chk("rst_out_payload", out_payload_o, 128'h0);
        chk("rst_sb_r_addr", sb_r_addr_o, 20'h0);

        // Independent pair
        set_slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 64'hAAAA_0000_0000_0001);
        set_slot(1, 5'd4, 5'd5, 5'd6, 1'b0, 64'hBBBB_0000_0000_0002);
        in_valid_i = 2'b11;
        settle();
        chk("pair_empty_sb_is", sb_is_o, 2'b00);
        step();
        in_valid_i = 2'b00;
        settle();
        chk("pair_r_addr", sb_r_addr_o, {5'd6, 5'd5, 5'd3, 5'd2});
        chk("pair_w_addr", sb_w_addr_o, {5'd4, 5'd1});
        chk("pair_sb_is", sb_is_o, 2'b11);
        step();
        settle();
        chk("pair_out_valid", out_valid_o, 2'b11);
        chk("pair_out_payload", out_payload_o, {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001});
        chk("pair_out_rd", out_rd_o, {5'd4, 5'd1});
        chk("pair_out_w_id", out_w_id_o, 5'h0A);
        chk("pair_out_r_id", out_r_id_o, 16'h4321);
        chk("pair_drained_sb_is", sb_is_o, 2'b00);
        step();
        settle();
        chk("pair_out_clear", out_valid_o, 2'b00);

        // RAW inside the pair (next.rs0 == head.rd)
        set_slot(0, 5'd5, 5'd1, 5'd2, 1'b0, 64'h1111);
        set_slot(1, 5'd6, 5'd5, 5'd0, 1'b0, 64'h2222);
        in_valid_i = 2'b11;
        step();
        in_valid_i = 2'b00;
        settle();
        chk("raw_sb_is_1", sb_is_o, 2'b01);
        step();
        settle();
        chk("raw_out_valid_1", out_valid_o, 2'b01);
        chk("raw_out_rd_1", out_rd_o[0], 5'd5);
        chk("raw_sb_is_2", sb_is_o, 2'b01);
        step();
        settle();
        chk("raw_out_rd_2", out_rd_o[0], 5'd6);
        chk("raw_out_payload_2", out_payload_o[0], 64'h2222);
        chk("raw_sb_is_3", sb_is_o, 2'b00);
        step();
        settle();
        chk("raw_out_clear", out_valid_o, 2'b00);

        // WAW, then a pipe0-only instruction behind the second writer
        set_slot(0, 5'd7, 5'd1, 5'd1, 1'b0, 64'hA7);
        set_slot(1, 5'd7, 5'd2, 5'd2, 1'b0, 64'hB7);
        in_valid_i = 2'b11;
        step();
        settle();
        chk("waw_sb_is", sb_is_o, 2'b01);
        set_slot(0, 5'd9, 5'd0, 5'd0, 1'b1, 64'hC9);
        in_valid_i = 2'b01;
        step();
        in_valid_i = 2'b00;
        settle();
        chk("p0only_next_sb_is", sb_is_o, 2'b01);
        chk("waw_out_payload_a", out_payload_o[0], 64'hA7);
        step();
        settle();
        chk("p0only_head_sb_is", sb_is_o, 2'b01);
        chk("waw_out_payload_b", out_payload_o[0], 64'hB7);
        step();
        settle();
        chk("p0only_out_valid", out_valid_o, 2'b01);
        chk("p0only_out_rd", out_rd_o[0], 5'd9);
        chk("p0only_out_payload", out_payload_o[0], 64'hC9);
        chk("p0only_sb_is_empty", sb_is_o, 2'b00);
        step();

        // Scoreboard source not ready for three cycles, buffer fills meanwhile
        sb_r_valid_i = 4'b1101;
        set_slot(0, 5'd10, 5'd11, 5'd12, 1'b0, 64'h10);
        set_slot(1, 5'd13, 5'd14, 5'd15, 1'b0, 64'h13);
        in_valid_i = 2'b11;
        step();
        set_slot(0, 5'd16, 5'd1, 5'd2, 1'b0, 64'h16);
        set_slot(1, 5'd17, 5'd3, 5'd4, 1'b0, 64'h17);
        settle();
        chk("sbnr_sb_is_1", sb_is_o, 2'b00);
        chk("sbnr_in_ready_half", in_ready_o, 1'b1);
        step();
        in_valid_i = 2'b00;
        settle();
        chk("sbnr_sb_is_2", sb_is_o, 2'b00);
        chk("full_in_ready", in_ready_o, 1'b0);
        step();
        settle();
        chk("sbnr_sb_is_3", sb_is_o, 2'b00);
        step();
        sb_r_valid_i = 4'hF;
        sb_w_id_i    = 5'h0C;
        settle();
        chk("sbnr_rise_sb_is", sb_is_o, 2'b11);
        chk("full_no_bypass_ready", in_ready_o, 1'b0);
        step();
        settle();
        chk("sbnr_out_rd", out_rd_o, {5'd13, 5'd10});
        chk("sbnr_out_w_id", out_w_id_o, 5'h0C);

        // Downstream stall holds the output pair and blocks issue
        out_ready_i = 1'b0;
        settle();
        chk("stall_sb_is", sb_is_o, 2'b00);
        step();
        settle();
        chk("stall_out_valid", out_valid_o, 2'b11);
        chk("stall_out_rd", out_rd_o, {5'd13, 5'd10});
        chk("stall_sb_is_2", sb_is_o, 2'b00);
        out_ready_i = 1'b1;
        sb_w_id_i   = 5'h15;
        settle();
        chk("unstall_sb_is", sb_is_o, 2'b11);
        step();
        settle();
        chk("unstall_out_rd", out_rd_o, {5'd17, 5'd16});
        chk("unstall_out_w_id", out_w_id_o, 5'h15);

        // Flush with three buffered entries and one registered instruction
        set_slot(0, 5'd20, 5'd0, 5'd0, 1'b0, 64'h20);
        set_slot(1, 5'd21, 5'd0, 5'd20, 1'b0, 64'h21);
        in_valid_i = 2'b11;
        step();
        set_slot(0, 5'd22, 5'd1, 5'd1, 1'b0, 64'h22);
        set_slot(1, 5'd23, 5'd2, 5'd2, 1'b0, 64'h23);
        settle();
        chk("raw_rs1_sb_is", sb_is_o, 2'b01);
        step();
        set_slot(0, 5'd24, 5'd0, 5'd0, 1'b0, 64'h24);
        set_slot(1, 5'd25, 5'd0, 5'd0, 1'b0, 64'h25);
        flush_i = 1'b1;
        settle();
        chk("preflush_out_valid", out_valid_o, 2'b01);
        chk("flush_cycle_sb_is", sb_is_o, 2'b00);
        step();
        flush_i    = 1'b0;
        in_valid_i = 2'b00;
        settle();
        chk("flush_out_valid", out_valid_o, 2'b00);
        chk("flush_sb_is", sb_is_o, 2'b00);
        chk("flush_in_ready", in_ready_o, 1'b1);
        step();
        settle();
        chk("flush_empty_sb_is", sb_is_o, 2'b00);

        // Single entry after flush issues alone
        set_slot(0, 5'd3, 5'd0, 5'd0, 1'b0, 64'h5151);
        in_valid_i = 2'b01;
        step();
        in_valid_i = 2'b00;
        settle();
        chk("single_sb_is", sb_is_o, 2'b01);
        chk("single_w_addr", sb_w_addr_o[0], 5'd3);
        step();
        settle();
        chk("single_out_valid", out_valid_o, 2'b01);
        chk("single_out_payload", out_payload_o[0], 64'h5151);

        // Reset mid-stream
        set_slot(0, 5'd2, 5'd0, 5'd0, 1'b0, 64'h02);
        set_slot(1, 5'd4, 5'd0, 5'd0, 1'b0, 64'h04);
        in_valid_i = 2'b11;
        step();
        set_slot(0, 5'd8, 5'd1, 5'd1, 1'b0, 64'h08);
        set_slot(1, 5'd9, 5'd1, 5'd1, 1'b0, 64'h09);
        settle();
        chk("prerst_sb_is", sb_is_o, 2'b11);
        step();
        in_valid_i = 2'b00;
        settle();
        chk("prerst_out_valid", out_valid_o, 2'b11);
        rst_n = 1'b0;
        step();
        settle();
        chk("midrst_out_valid", out_valid_o, 2'b00);
        chk("midrst_out_rd", out_rd_o, 10'h0);
        chk("midrst_out_payload", out_payload_o, 128'h0);
        chk("midrst_out_w_id", out_w_id_o, 5'h0);
        chk("midrst_out_r_id", out_r_id_o, 16'h0);
        chk("midrst_sb_is", sb_is_o, 2'b00);
        chk("midrst_w_addr", sb_w_addr_o, 10'h0);
        chk("midrst_in_ready", in_ready_o, 1'b1);
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
